// File: rtl/text_line_renderer_pkg.sv
// Shared definitions for the text line renderer: line widths for the lag and
// resolution text sources, the bitmap load position and the renderer state type.
package text_line_renderer_pkg;

`ifndef LAGLINE_SIZE
`define LAGLINE_SIZE 128
`endif
`ifndef RESLINE_SIZE
`define RESLINE_SIZE 128
`endif

  localparam int unsigned LAGLINE_WIDTH  = `LAGLINE_SIZE;
  localparam int unsigned RESLINE_WIDTH  = `RESLINE_SIZE;
  // The text line generator finishes writing by counterX ~38.
  localparam int unsigned LOAD_X_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/text_line_renderer_if.sv
// Timing inputs, bitmap and pixel stream outputs of one text line renderer.
interface text_line_renderer_if
  import text_line_renderer_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LAGLINE_WIDTH
);
  logic [11:0]           counterX;
  logic [11:0]           visible_counterX;
  logic                  line_valid;
  logic [LINE_WIDTH-1:0] line_data;
  logic [11:0]           x_start;
  logic [1:0]            h_scale_log2;
  logic                  pixel_valid;
  logic                  pixel_on;
  logic                  pixel_shadow;
  logic                  busy;

  modport master (
    output counterX, visible_counterX, line_valid, line_data, x_start, h_scale_log2,
    input  pixel_valid, pixel_on, pixel_shadow, busy
  );

  modport slave (
    input  counterX, visible_counterX, line_valid, line_data, x_start, h_scale_log2,
    output pixel_valid, pixel_on, pixel_shadow, busy
  );
endinterface

// File: rtl/text_line_renderer.sv
// Text line renderer: samples a text line bitmap at LOAD_X and serializes it,
// MSB first, into a per-pixel on/off stream starting one clock after
// visible_counterX == x_start, each bit repeated 2^h_scale_log2 clocks.
// Optional macro TEXT_SHADOW_EN builds the drop-shadow output.
module text_line_renderer
  import text_line_renderer_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LAGLINE_WIDTH,
  parameter int unsigned LOAD_X     = LOAD_X_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  text_line_renderer_if.slave bus
);
  localparam int unsigned BW = $clog2(LINE_WIDTH) + 1;

  state_t                state, state_n;
  logic [LINE_WIDTH-1:0] sr, sr_n;
  logic [1:0]            scale, scale_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [2:0]            rep_cnt, rep_cnt_n;
  logic [2:0]            rep_max;
  logic [11:0]           out_cnt, last_cnt;
`ifdef TEXT_SHADOW_EN
  logic                  prev, prev_n;
`endif

  // Output cycle index and its last value, compared in 12 bits (max 1024 fits).
  always_comb begin
    rep_max  = 3'((4'd1 << scale) - 4'd1);
    out_cnt  = (12'(bit_cnt) << scale) + 12'(rep_cnt);
    last_cnt = (12'(LINE_WIDTH) << scale) - 12'd1;
  end

  // Next-state, shift register and counter update; counterX==0 overrides all.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    scale_n   = scale;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
`ifdef TEXT_SHADOW_EN
    prev_n    = prev;
`endif
    if (bus.counterX == '0) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.counterX == 12'(LOAD_X) && bus.line_valid) begin
            state_n   = ARMED;
            sr_n      = bus.line_data;
            scale_n   = bus.h_scale_log2;
            bit_cnt_n = '0;
            rep_cnt_n = '0;
`ifdef TEXT_SHADOW_EN
            prev_n    = 1'b0;
`endif
          end
        end
        ARMED: begin
          if (bus.visible_counterX == bus.x_start) state_n = SHIFT;
        end
        SHIFT: begin
          if (rep_cnt == rep_max) begin
            rep_cnt_n = '0;
            sr_n      = sr << 1;
            bit_cnt_n = bit_cnt + BW'(1);
`ifdef TEXT_SHADOW_EN
            prev_n    = sr[LINE_WIDTH-1];
`endif
          end else begin
            rep_cnt_n = rep_cnt + 3'd1;
          end
          if (out_cnt == last_cnt) state_n = DONE;
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // State/data registers; pixel outputs are registered from the next state so
  // they appear exactly one clock after the x_start match.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      sr              <= '0;
      scale           <= '0;
      bit_cnt         <= '0;
      rep_cnt         <= '0;
      bus.pixel_valid <= 1'b0;
      bus.pixel_on    <= 1'b0;
    end else begin
      state           <= state_n;
      sr              <= sr_n;
      scale           <= scale_n;
      bit_cnt         <= bit_cnt_n;
      rep_cnt         <= rep_cnt_n;
      bus.pixel_valid <= (state_n == SHIFT);
      bus.pixel_on    <= (state_n == SHIFT) && sr_n[LINE_WIDTH-1];
    end
  end

`ifdef TEXT_SHADOW_EN
  // Shadow is set on a 0 bit that follows a 1 bit, for the full scaled width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev             <= 1'b0;
      bus.pixel_shadow <= 1'b0;
    end else begin
      prev             <= prev_n;
      bus.pixel_shadow <= (state_n == SHIFT) && !sr_n[LINE_WIDTH-1] && prev_n;
    end
  end
`else
  // Shadow feature not built.
  always_comb bus.pixel_shadow = 1'b0;
`endif

  // Busy whenever a line is loaded and not yet retired.
  always_comb bus.busy = (state != IDLE);

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed bench for text_line_renderer with a 256-clock synthetic video line
// (visible_counterX = counterX - 48) and a 16-bit bitmap.
module tb_text_line_renderer;
  localparam int unsigned LW       = 16;
  localparam int unsigned LINE_LEN = 256;
  localparam int unsigned NONE     = 999;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int unsigned cx;

  logic valid_a  [LINE_LEN];
  logic on_a     [LINE_LEN];
  logic shadow_a [LINE_LEN];
  logic busy_a   [LINE_LEN];
  logic rst_valid, rst_on, rst_shadow, rst_busy;

  text_line_renderer_if #(.LINE_WIDTH(LW)) bus ();

  text_line_renderer #(.LINE_WIDTH(LW), .LOAD_X(40)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cx = (cx + 1) % LINE_LEN;
    bus.counterX         = 12'(cx);
    bus.visible_counterX = 12'(cx) - 12'd48;
  endtask

  // Runs one full line from counterX==0 back to counterX==0, recording the
  // outputs seen during each cycle at the index of that cycle's counterX.
  task automatic run_line(input int unsigned chg_cx, input logic [1:0] chg_scale,
                          input int unsigned rst_cx);
    for (int unsigned n = 0; n < LINE_LEN; n++) begin
      tick();
      valid_a[cx]  = bus.pixel_valid;
      on_a[cx]     = bus.pixel_on;
      shadow_a[cx] = bus.pixel_shadow;
      busy_a[cx]   = bus.busy;
      if (cx == chg_cx) begin
        bus.h_scale_log2 = chg_scale;
        bus.line_data    = 16'h0F0F;
      end
      if (cx == rst_cx) begin
        reset = 1'b1;
        #1;
        rst_valid  = bus.pixel_valid;
        rst_on     = bus.pixel_on;
        rst_shadow = bus.pixel_shadow;
        rst_busy   = bus.busy;
        reset = 1'b0;
      end
    end
  endtask

  function automatic int count_valid();
    int c = 0;
    for (int unsigned i = 0; i < LINE_LEN; i++) c += int'(valid_a[i]);
    return c;
  endfunction

  function automatic int count_busy();
    int c = 0;
    for (int unsigned i = 0; i < LINE_LEN; i++) c += int'(busy_a[i]);
    return c;
  endfunction

  function automatic int count_shadow();
    int c = 0;
    for (int unsigned i = 0; i < LINE_LEN; i++) c += int'(shadow_a[i]);
    return c;
  endfunction

  function automatic logic [31:0] on_vec(input int unsigned lo, input int unsigned n);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < n; i++) v = {v[30:0], on_a[(lo + i) % LINE_LEN]};
    return v;
  endfunction

  function automatic logic [31:0] shadow_vec(input int unsigned lo, input int unsigned n);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < n; i++) v = {v[30:0], shadow_a[(lo + i) % LINE_LEN]};
    return v;
  endfunction

  task automatic setup(input logic lv, input logic [15:0] data, input logic [1:0] sc,
                       input logic [11:0] xs);
    bus.line_valid   = lv;
    bus.line_data    = data;
    bus.h_scale_log2 = sc;
    bus.x_start      = xs;
  endtask

  initial begin
    cx = 0;
    reset = 1'b1;
    bus.counterX         = '0;
    bus.visible_counterX = 12'd0 - 12'd48;
    setup(1'b0, '0, 2'd0, 12'd100);
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid",  32'(bus.pixel_valid),  32'd0);
    check("reset_on",     32'(bus.pixel_on),     32'd0);
    check("reset_shadow", 32'(bus.pixel_shadow), 32'd0);
    check("reset_busy",   32'(bus.busy),         32'd0);
    reset = 1'b0;

    // 1: basic serialization, scale 0
    setup(1'b1, 16'hA5F0, 2'd0, 12'd100);
    run_line(NONE, 2'd0, NONE);
    check("t1_before_start", 32'(valid_a[148]), 32'd0);
    check("t1_first_valid",  32'(valid_a[149]), 32'd1);
    check("t1_valid_count",  32'(count_valid()), 32'd16);
    check("t1_bits",         on_vec(149, 16), 32'h0000A5F0);
    check("t1_after_end",    32'(valid_a[165]), 32'd0);
    check("t1_busy_load",    32'(busy_a[40]), 32'd0);
    check("t1_busy_done",    32'(busy_a[200]), 32'd1);
    check("t1_busy_count",   32'(count_busy()), 32'd216);

    // 2: scale 1, mid-line scale/data change ignored
    setup(1'b1, 16'hA5F0, 2'd1, 12'd100);
    run_line(150, 2'd3, NONE);
    check("t2_valid_count", 32'(count_valid()), 32'd32);
    check("t2_bits",        on_vec(149, 32), 32'hCC33FF00);
    check("t2_last_valid",  32'(valid_a[180]), 32'd1);
    check("t2_after_end",   32'(valid_a[181]), 32'd0);

    // 3: vertical gate closed at LOAD_X
    setup(1'b0, 16'hA5F0, 2'd0, 12'd100);
    run_line(NONE, 2'd0, NONE);
    check("t3_valid_count", 32'(count_valid()), 32'd0);
    check("t3_busy_count",  32'(count_busy()), 32'd0);

    // 4: overrun, start 5 pixels before line end
    setup(1'b1, 16'hA5F0, 2'd0, 12'd202);
    run_line(NONE, 2'd0, NONE);
    check("t4_valid_count", 32'(count_valid()), 32'd6);
    check("t4_bits",        on_vec(251, 6), 32'h00000029);
    check("t4_busy_wrap",   32'(busy_a[0]), 32'd1);
    setup(1'b1, 16'hA5F0, 2'd0, 12'd100);
    run_line(NONE, 2'd0, NONE);
    check("t4_drop_valid",  32'(valid_a[1]), 32'd0);
    check("t4_drop_busy",   32'(busy_a[1]), 32'd0);
    check("t4_reload_cnt",  32'(count_valid()), 32'd16);
    check("t4_reload_bits", on_vec(149, 16), 32'h0000A5F0);

    // 5: asynchronous reset during bit 7
    setup(1'b1, 16'hA5F0, 2'd0, 12'd100);
    run_line(NONE, 2'd0, 156);
    check("t5_bit7_on",     32'(on_a[156]), 32'd1);
    check("t5_rst_valid",   32'(rst_valid), 32'd0);
    check("t5_rst_on",      32'(rst_on), 32'd0);
    check("t5_rst_shadow",  32'(rst_shadow), 32'd0);
    check("t5_rst_busy",    32'(rst_busy), 32'd0);
    check("t5_valid_count", 32'(count_valid()), 32'd8);
    check("t5_busy_count",  32'(count_busy()), 32'd116);

    // 6: drop shadow
    setup(1'b1, 16'hC000, 2'd0, 12'd100);
    run_line(NONE, 2'd0, NONE);
    check("t6_valid_count", 32'(count_valid()), 32'd16);
    check("t6_bits",        on_vec(149, 16), 32'h0000C000);
`ifdef TEXT_SHADOW_EN
    check("t6_shadow_bits",  shadow_vec(149, 16), 32'h00002000);
    check("t6_shadow_count", 32'(count_shadow()), 32'd1);
`else
    check("t6_shadow_bits",  shadow_vec(149, 16), 32'h00000000);
    check("t6_shadow_count", 32'(count_shadow()), 32'd0);
`endif

    // 7: x_start position coincides with LOAD_X; no later match this line
    setup(1'b1, 16'hA5F0, 2'd0, 12'hFF8);
    run_line(NONE, 2'd0, NONE);
    check("t7_valid_count", 32'(count_valid()), 32'd0);
    check("t7_armed_busy",  32'(busy_a[100]), 32'd1);
    check("t7_busy_count",  32'(count_busy()), 32'd216);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
